// File: rtl/seqgen_pkg.sv
// Shared types and constants for the step sequencer: FSM states, target
// register addresses and the enable-word builder.
package seqgen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_PER = 3'd1,
        WR_VOL = 3'd2,
        WR_EN  = 3'd3,
        WAIT   = 3'd4
    } state_t;

    localparam logic [2:0] ADDR_PERIOD_A = 3'd0;
    localparam logic [2:0] ADDR_VOL_A    = 3'd2;
    localparam logic [2:0] ADDR_ENABLE   = 3'd5;

    // A zero volume is a rest, so the tone-A enable bit follows volume != 0.
    function automatic logic [4:0] enable_word(input logic [3:0] vol,
                                               input logic       en_b,
                                               input logic       en_n);
        enable_word = {2'b00, (vol != 4'd0), en_b, en_n};
    endfunction

endpackage

// File: rtl/seq_write_arbiter_if.sv
// Host, pattern-table, control and register-write signals of the sequencer.
interface seq_write_arbiter_if;
    logic       host_wr;
    logic [2:0] host_addr;
    logic [4:0] host_data;
    logic       pat_wr;
    logic [2:0] pat_idx;
    logic [8:0] pat_data;
    logic [2:0] seq_len;
    logic [7:0] tempo;
    logic       cfg_en_b;
    logic       cfg_en_n;
    logic       start;
    logic       stop;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       busy;
    logic [2:0] step_idx;

    modport slave (
        input  host_wr, host_addr, host_data, pat_wr, pat_idx, pat_data,
               seq_len, tempo, cfg_en_b, cfg_en_n, start, stop,
        output write_strobe, address, data, busy, step_idx
    );

    modport master (
        output host_wr, host_addr, host_data, pat_wr, pat_idx, pat_data,
               seq_len, tempo, cfg_en_b, cfg_en_n, start, stop,
        input  write_strobe, address, data, busy, step_idx
    );
endinterface

// File: rtl/seq_write_arbiter_step_table.sv
// Pattern storage: NSTEPS entries of {period[4:0], volume[3:0]}, written
// synchronously and read combinationally.
module step_table #(
    parameter int NSTEPS = 8,
    parameter int IW     = $clog2(NSTEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [8:0]    wr_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [8:0]    rd_data_o
);
    logic [8:0] mem_q [NSTEPS];

    // Entry storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTEPS; i++) begin
                mem_q[i] <= 9'd0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/seq_write_arbiter.sv
// Sequencer replaying the step table as period/volume/enable register writes,
// sharing one registered write port with the host, which always wins.
module seq_write_arbiter
    import seqgen_pkg::*;
#(
    parameter int NSTEPS = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(NSTEPS);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] entry_q, entry_d;
    logic       stop_pend_q, stop_pend_d;
    logic       strobe_q, strobe_d;
    logic [2:0] addr_q, addr_d;
    logic [4:0] data_q, data_d;
    logic       busy_q;

    logic [2:0] next_step_s;
    logic [2:0] rd_step_s;
    logic [8:0] rd_entry_s;
    logic       seq_wr_s;
    logic [2:0] seq_addr_s;
    logic [4:0] seq_data_s;
    logic       stop_now_s;

    assign next_step_s = (step_q == bus.seq_len) ? 3'd0 : step_q + 3'd1;
    // The table is only consulted on entry to WR_PER: step 0 from IDLE, else the next step.
    assign rd_step_s   = (state_q == IDLE) ? 3'd0 : next_step_s;
    assign stop_now_s  = stop_pend_q | bus.stop;

    step_table #(.NSTEPS(NSTEPS)) u_table (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.pat_wr),
        .wr_idx_i  (bus.pat_idx[IW-1:0]),
        .wr_data_i (bus.pat_data),
        .rd_idx_i  (rd_step_s[IW-1:0]),
        .rd_data_o (rd_entry_s)
    );

    // Next-state logic; a WR state only advances when the host leaves the port free.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        entry_d     = entry_q;
        stop_pend_d = stop_pend_q;
        seq_wr_s    = 1'b0;
        seq_addr_s  = 3'd0;
        seq_data_s  = 5'd0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = WR_PER;
                    step_d  = 3'd0;
                    entry_d = rd_entry_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_PER: begin
                seq_wr_s    = 1'b1;
                seq_addr_s  = ADDR_PERIOD_A;
                seq_data_s  = entry_q[8:4];
                stop_pend_d = stop_now_s;
                if (bus.host_wr) begin
                    state_d = WR_PER;
                end else begin
                    state_d = WR_VOL;
                end
            end
            WR_VOL: begin
                seq_wr_s    = 1'b1;
                seq_addr_s  = ADDR_VOL_A;
                seq_data_s  = {1'b0, entry_q[3:0]};
                stop_pend_d = stop_now_s;
                if (bus.host_wr) begin
                    state_d = WR_VOL;
                end else begin
                    state_d = WR_EN;
                end
            end
            WR_EN: begin
                seq_wr_s    = 1'b1;
                seq_addr_s  = ADDR_ENABLE;
                seq_data_s  = enable_word(entry_q[3:0], bus.cfg_en_b, bus.cfg_en_n);
                stop_pend_d = stop_now_s;
                if (bus.host_wr) begin
                    state_d = WR_EN;
                end else if (stop_now_s) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (bus.tempo == 8'd0) begin
                    state_d = WR_PER;
                    step_d  = next_step_s;
                    entry_d = rd_entry_s;
                end else begin
                    state_d = WAIT;
                    cnt_d   = bus.tempo;
                end
            end
            WAIT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q <= 8'd1) begin
                    state_d = WR_PER;
                    cnt_d   = 8'd0;
                    step_d  = next_step_s;
                    entry_d = rd_entry_s;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    // Write-port arbitration: host first, then the sequencer, else a quiet bus.
    always_comb begin
        strobe_d = 1'b0;
        addr_d   = 3'd0;
        data_d   = 5'd0;
        if (bus.host_wr) begin
            strobe_d = 1'b1;
            addr_d   = bus.host_addr;
            data_d   = bus.host_data;
        end else if (seq_wr_s) begin
            strobe_d = 1'b1;
            addr_d   = seq_addr_s;
            data_d   = seq_data_s;
        end else begin
            strobe_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            cnt_q       <= 8'd0;
            entry_q     <= 9'd0;
            stop_pend_q <= 1'b0;
            strobe_q    <= 1'b0;
            addr_q      <= 3'd0;
            data_q      <= 5'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            stop_pend_q <= stop_pend_d;
            strobe_q    <= strobe_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.write_strobe = strobe_q;
    assign bus.address      = addr_q;
    assign bus.data         = data_q;
    assign bus.busy         = busy_q;
    assign bus.step_idx     = step_q;

endmodule

// File: tb/tb_seq_write_arbiter.sv
// Directed bench for seq_write_arbiter: a queue-based step model checked every
// cycle, plus literal expectations for the key write sequences.
module tb_seq_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_write_arbiter_if bus_if ();

    seq_write_arbiter #(.NSTEPS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0] m_mem [8];
    logic [2:0] m_pend [$];
    logic [8:0] m_entry   = 9'd0;
    logic [2:0] m_idx     = 3'd0;
    bit         m_run     = 1'b0;
    bit         m_stopreq = 1'b0;
    bit         was_run   = 1'b0;
    int         m_wait    = 0;
    logic [2:0] m_a       = 3'd0;
    logic       e_stb     = 1'b0;
    logic [2:0] e_addr    = 3'd0;
    logic [4:0] e_data    = 5'd0;
    logic       e_busy    = 1'b0;
    logic [2:0] e_idx     = 3'd0;

    function automatic logic [4:0] wr_value(input logic [2:0] a);
        case (a)
            3'd0:    return m_entry[8:4];
            3'd2:    return {1'b0, m_entry[3:0]};
            default: return {2'b00, (m_entry[3:0] != 4'd0), bus_if.cfg_en_b, bus_if.cfg_en_n};
        endcase
    endfunction

    task automatic load_step();
        m_entry = m_mem[m_idx];
        m_pend.delete();
        m_pend.push_back(3'd0);
        m_pend.push_back(3'd2);
        m_pend.push_back(3'd5);
    endtask

    task automatic next_step();
        m_idx = (m_idx == bus_if.seq_len) ? 3'd0 : m_idx + 3'd1;
        load_step();
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 9'd0;
            m_pend.delete();
            m_run = 1'b0; m_stopreq = 1'b0; m_wait = 0; m_idx = 3'd0; m_entry = 9'd0;
            e_stb = 1'b0; e_addr = 3'd0; e_data = 5'd0; e_busy = 1'b0; e_idx = 3'd0;
        end else begin
            was_run = m_run;
            e_stb = 1'b0; e_addr = 3'd0; e_data = 5'd0;
            if (bus_if.host_wr) begin
                e_stb = 1'b1; e_addr = bus_if.host_addr; e_data = bus_if.host_data;
            end
            if (was_run) begin
                if (m_pend.size() > 0) begin
                    if (bus_if.stop) m_stopreq = 1'b1;
                    if (!bus_if.host_wr) begin
                        m_a = m_pend.pop_front();
                        e_stb = 1'b1; e_addr = m_a; e_data = wr_value(m_a);
                        if (m_pend.size() == 0) begin
                            if (m_stopreq) begin
                                m_run = 1'b0; m_stopreq = 1'b0;
                            end else if (bus_if.tempo == 8'd0) begin
                                next_step();
                            end else begin
                                m_wait = int'(bus_if.tempo);
                            end
                        end
                    end
                end else if (bus_if.stop) begin
                    m_run = 1'b0;
                end else begin
                    m_wait--;
                    if (m_wait == 0) next_step();
                end
            end else if (bus_if.start && !bus_if.stop) begin
                m_run = 1'b1; m_idx = 3'd0;
                load_step();
            end
            if (bus_if.pat_wr) m_mem[bus_if.pat_idx] = bus_if.pat_data;
            e_busy = m_run;
            e_idx  = m_idx;
        end
    end

    // ---------------- per-cycle compare and strobe log ----------------
    logic [2:0] lg_addr [$];
    logic [4:0] lg_data [$];
    int         lg_cyc  [$];

    always @(negedge clk) begin
        cyc++;
        chk("strobe",   32'(bus_if.write_strobe), 32'(e_stb));
        chk("address",  32'(bus_if.address),      32'(e_addr));
        chk("data",     32'(bus_if.data),         32'(e_data));
        chk("busy",     32'(bus_if.busy),         32'(e_busy));
        chk("step_idx", 32'(bus_if.step_idx),     32'(e_idx));
        if (bus_if.write_strobe) begin
            lg_addr.push_back(bus_if.address);
            lg_data.push_back(bus_if.data);
            lg_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        lg_addr.delete(); lg_data.delete(); lg_cyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); bus_if.start = 1'b1;
        @(negedge clk); bus_if.start = 1'b0;
    endtask

    task automatic write_pat(input logic [2:0] idx, input logic [8:0] val);
        @(negedge clk);
        bus_if.pat_wr = 1'b1; bus_if.pat_idx = idx; bus_if.pat_data = val;
        @(negedge clk);
        bus_if.pat_wr = 1'b0;
    endtask

    task automatic chk_log(input string name, input int i, input logic [2:0] a, input logic [4:0] d);
        if (i < lg_addr.size()) begin
            chk({name, "_addr"}, 32'(lg_addr[i]), 32'(a));
            chk({name, "_data"}, 32'(lg_data[i]), 32'(d));
        end else begin
            chk({name, "_present"}, 32'(0), 32'(1));
        end
    endtask

    logic [2:0] exp_a1 [7] = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5, 3'd0};
    logic [4:0] exp_d1 [7] = '{5'h1A, 5'h08, 5'h07, 5'h05, 5'h00, 5'h03, 5'h1A};

    initial begin
        bus_if.host_wr = 1'b0; bus_if.host_addr = 3'd0; bus_if.host_data = 5'd0;
        bus_if.pat_wr = 1'b0; bus_if.pat_idx = 3'd0; bus_if.pat_data = 9'd0;
        bus_if.seq_len = 3'd0; bus_if.tempo = 8'd0;
        bus_if.cfg_en_b = 1'b1; bus_if.cfg_en_n = 1'b1;
        bus_if.start = 1'b0; bus_if.stop = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_strobe", 32'(bus_if.write_strobe), 32'(0));
        chk("rst_busy",   32'(bus_if.busy),         32'(0));
        chk("rst_step",   32'(bus_if.step_idx),     32'(0));
        chk("rst_addr",   32'(bus_if.address),      32'(0));
        chk("rst_data",   32'(bus_if.data),         32'(0));
        rst = 1'b0;

        // Two-step pattern, tempo 2, wrap back to step 0.
        write_pat(3'd0, 9'h1A8);
        write_pat(3'd1, 9'h050);
        bus_if.seq_len = 3'd1; bus_if.tempo = 8'd2;
        clear_log();
        pulse_start();
        repeat (14) @(negedge clk);
        for (int i = 0; i < 7; i++) chk_log("seq", i, exp_a1[i], exp_d1[i]);
        if (lg_cyc.size() >= 4) chk("seq_gap", 32'(lg_cyc[3] - lg_cyc[2]), 32'(3));
        else chk("seq_gap_present", 32'(0), 32'(1));
        @(negedge clk); bus_if.stop = 1'b1;
        @(negedge clk); bus_if.stop = 1'b0;
        repeat (6) @(negedge clk);
        chk("stop1_busy", 32'(bus_if.busy), 32'(0));

        // Host write collides with the volume write.
        bus_if.seq_len = 3'd0;
        clear_log();
        pulse_start();
        @(negedge clk);
        bus_if.host_wr = 1'b1; bus_if.host_addr = 3'd3; bus_if.host_data = 5'd9;
        @(negedge clk);
        bus_if.host_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk_log("col", 0, 3'd0, 5'h1A);
        chk_log("col", 1, 3'd3, 5'h09);
        chk_log("col", 2, 3'd2, 5'h08);
        chk_log("col", 3, 3'd5, 5'h07);
        if (lg_cyc.size() >= 4) chk("col_span", 32'(lg_cyc[3] - lg_cyc[0]), 32'(3));
        else chk("col_span_present", 32'(0), 32'(1));
        @(negedge clk); bus_if.stop = 1'b1;
        @(negedge clk); bus_if.stop = 1'b0;
        repeat (6) @(negedge clk);

        // Stop sampled while in WR_PER: the step still completes.
        clear_log();
        @(negedge clk); bus_if.start = 1'b1;
        @(negedge clk); bus_if.start = 1'b0; bus_if.stop = 1'b1;
        @(negedge clk); bus_if.stop = 1'b0;
        repeat (8) @(negedge clk);
        chk("stopwr_count", 32'(lg_addr.size()), 32'(3));
        chk_log("stopwr", 2, 3'd5, 5'h07);
        chk("stopwr_busy", 32'(bus_if.busy), 32'(0));

        // Start and stop together in IDLE.
        clear_log();
        @(negedge clk); bus_if.start = 1'b1; bus_if.stop = 1'b1;
        @(negedge clk); bus_if.start = 1'b0; bus_if.stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("both_count", 32'(lg_addr.size()), 32'(0));
        chk("both_busy",  32'(bus_if.busy),    32'(0));

        // Reset in WAIT with a long tempo, then replay a cleared table.
        bus_if.tempo = 8'd200; bus_if.cfg_en_n = 1'b0;
        pulse_start();
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy",   32'(bus_if.busy),         32'(0));
        chk("rst_mid_strobe", 32'(bus_if.write_strobe), 32'(0));
        clear_log();
        @(negedge clk);
        bus_if.host_wr = 1'b1; bus_if.host_addr = 3'd3; bus_if.host_data = 5'd9;
        @(negedge clk);
        bus_if.host_wr = 1'b0;
        rst = 1'b0;
        chk("rst_host_blocked", 32'(lg_addr.size()), 32'(0));
        pulse_start();
        repeat (6) @(negedge clk);
        chk_log("post_rst", 0, 3'd0, 5'h00);
        chk_log("post_rst", 1, 3'd2, 5'h00);
        chk_log("post_rst", 2, 3'd5, 5'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_write_arbiter.md
SEQ_WRITE_ARBITER -- requirements
Module: seq_write_arbiter

Interface
REQ-001 SHALL have parameter NSTEPS, default 8, meaning the pattern table depth (power of two).
REQ-002 SHALL have port clk  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port host_wr  in  1  one-cycle host register-write request.
REQ-005 SHALL have port host_addr  in  3  host write address.
REQ-006 SHALL have port host_data  in  5  host write data.
REQ-007 SHALL have port pat_wr  in  1  pattern-table write enable.
REQ-008 SHALL have port pat_idx  in  3  pattern-table write index.
REQ-009 SHALL have port pat_data  in  9  step entry: [8:4] period data, [3:0] volume.
REQ-010 SHALL have port seq_len  in  3  index of the last step played.
REQ-011 SHALL have port tempo  in  8  wait cycles between steps.
REQ-012 SHALL have port cfg_en_b / cfg_en_n  in  1 each  enable bits for channel B and noise.
REQ-013 SHALL have port start / stop  in  1 each  sequencer control pulses.
REQ-014 SHALL have port write_strobe  out  1  register-write strobe to the signal generator.
REQ-015 SHALL have port address / data  out  3 / 5  register-write address and data.
REQ-016 SHALL have port busy / step_idx  out  1 / 3  sequencer running; current step index.

Function
REQ-017 SHALL use FSM states IDLE, WR_PER, WR_VOL, WR_EN, WAIT.
REQ-018 SHALL make start in IDLE reset step_idx to 0 and go to WR_PER; start in any other state is ignored.
REQ-019 SHALL present in WR_PER address 0 with data = entry[8:4].
REQ-020 SHALL present in WR_VOL address 2 with data = {0, entry[3:0]}.
REQ-021 SHALL present in WR_EN address 5 with data = {00, entry[3:0]!=0, cfg_en_b, cfg_en_n}; volume 0 is a rest.
REQ-022 SHALL advance each WR state only when its write has been issued.
REQ-023 SHALL make WR_EN go to WAIT and load the wait counter with tempo.
REQ-024 SHALL make WAIT decrement the counter to 0 and then advance step_idx; tempo=0 gives no WAIT cycles.
REQ-025 SHALL wrap step_idx from seq_len to 0 and continue in WR_PER.
REQ-026 SHALL register all outputs; a write decided at edge k is visible from edge k+1 for exactly one cycle.
REQ-027 SHALL give the uncontended step sequence: start sampled at edge k produces strobes after edges k+1, k+2 and k+3 (period, volume, enable).
REQ-028 SHALL pass a host write sampled at edge k through to the outputs after edge k+1, with 1-cycle latency.
REQ-029 SHALL give host_wr absolute priority: on collision the sequencer holds its state and retries next cycle; starvation under continuous host_wr is permitted.
REQ-030 SHALL hold write_strobe=0 with address/data at 0 when no write is issued.
REQ-031 SHALL make stop in WAIT go to IDLE next edge, and stop in a WR state finish the remaining writes of that step, then go to IDLE.
REQ-032 SHALL give stop priority over start when both are asserted in the same cycle.
REQ-033 SHALL accept pat_wr in any state; an entry is read when WR_PER is entered, and a write to the step being played affects the next pass only.
REQ-034 SHALL make busy=1 in every state except IDLE.

Reset
REQ-035 SHALL on rst force IDLE; write_strobe, address, data, busy and step_idx to 0; wait counter to 0; all pattern entries to 0.
REQ-036 SHALL on rst mid-sequence abandon the pending write with no strobe, and SHALL pass no host write until rst deasserts.

Structure
REQ-037 SHALL place the state enum and register-address constants (ADDR_PERIOD_A=0, ADDR_VOL_A=2, ADDR_ENABLE=5) in the shared package seqgen_pkg.
REQ-038 SHALL implement the pattern storage as one sub-module step_table (NSTEPS x 9 registers, synchronous write, combinational read).

Verification
REQ-039 SHALL cover: pattern {0x1A,8},{0x05,0}, seq_len=1, tempo=2, start -> strobes (0,0x1A),(2,8),(5,0x07), 2 idle cycles, then (0,0x05),(2,0),(5,0x03), then wrap to step 0.
REQ-040 SHALL cover: host_wr addr 3 data 9 in the same cycle as the WR_VOL write -> host write out first, volume write one cycle later, no lost strobe.
REQ-041 SHALL cover: stop during WR_PER -> volume and enable writes still issued, then busy=0 and no further strobes.
REQ-042 SHALL cover: start and stop together in IDLE -> remains IDLE, no strobe.
REQ-043 SHALL cover: rst asserted in WAIT with tempo=200 -> outputs 0 immediately, table reads 0; start after release -> writes (0,0),(2,0),(5,0x00 | cfg bits).
